// File: rtl/tinker_mem_responder.sv
// tinker_mem_responder: valid/ready data-memory target for the tinker core's
// load/store path. It accepts one request at a time, waits a fixed latency,
// commits the access, and holds the response until the requester takes it.
//
// The byte store is split into eight byte-wide banks interleaved on
// addr[2:0]. Any access of up to 8 consecutive bytes then touches each bank
// at most once. This holds even for unaligned addresses, so every bank needs
// only one read port and one write port.
module tinker_mem_responder #(
  parameter int unsigned MEM_BYTES = 524288,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned BANK_ROWS = MEM_BYTES / 8;
  localparam int unsigned ROW_W     = $clog2(BANK_ROWS);
  localparam int unsigned LOW_W     = ROW_W + 3;
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
  localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request latched at the accept edge.
  logic        we_q;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic [63:0] wdata_q;

  // Response registers.
  logic [63:0] rdata_q;
  logic        err_q;

  // Access being committed. In IDLE these are the live request inputs, which
  // only matters for LATENCY=1 where commit coincides with the accept edge.
  logic        acc_we;
  logic [63:0] acc_addr;
  logic [1:0]  acc_size;
  logic [63:0] acc_wdata;
  logic [3:0]  nbytes;
  logic [64:0] end_sum;
  logic        acc_err;

  logic        accept;
  logic        handshake;
  logic        commit;

  logic [7:0]  bank_rbyte [8];
  logic [63:0] rd_assembled;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, latency counter and handshake outputs.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign accept    = req_valid && req_ready;
  assign handshake = resp_valid && resp_ready;
  // The commit point is the edge that enters RESP.
  assign commit    = (state_d == ST_RESP) && (state_q != ST_RESP);

  // Select the access fields and range-check them with a 65-bit end address,
  // so addresses near 2^64 cannot wrap around into range.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_size  = req_size;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
    end
    nbytes  = 4'd1 << acc_size;
    end_sum = {1'b0, acc_addr} + 65'(nbytes);
    acc_err = end_sum > MEM_LIMIT;
  end

  // Byte banks. Bank b holds every byte whose address has addr[2:0] == b.
  for (genvar b = 0; b < 8; b++) begin : g_bank
    logic [7:0]       mem [BANK_ROWS];
    logic [2:0]       lane;
    logic             carry;
    logic [ROW_W-1:0] row;
    logic             hit;

    // lane: which byte of the access lands in this bank. The access wraps
    // into the next row for banks below the starting byte offset.
    assign lane  = 3'(b) - acc_addr[2:0];
    assign carry = acc_addr[2:0] > 3'(b);
    assign row   = acc_addr[LOW_W-1:3] + ROW_W'(carry);
    assign hit   = {1'b0, lane} < nbytes;

    assign bank_rbyte[b] = mem[row];

    // Byte write at the commit edge. Reset is checked so nothing is written
    // while the core is held in reset.
    // NOTE: the array has no reset. Its contents must survive reset, and a
    // reset on a memory would also stop it mapping onto RAM.
    always_ff @(posedge clk) begin
      if (reset_n && commit && acc_we && hit && !acc_err) begin
        mem[row] <= acc_wdata[{lane, 3'b000} +: 8];
      end
    end
  end

  // Gather the bytes of the access into little-endian order, zero-extended.
  always_comb begin
    logic [2:0] b_idx;
    rd_assembled = '0;
    b_idx        = '0;
    for (int i = 0; i < 8; i++) begin
      b_idx = acc_addr[2:0] + 3'(i);
      if (4'(i) < nbytes) begin
        rd_assembled[8*i +: 8] = bank_rbyte[b_idx];
      end
    end
  end

  // Request capture at accept. Response capture at commit; the response is
  // cleared once the requester takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (acc_we || acc_err) ? 64'd0 : rd_assembled;
      end else if (handshake) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
